pc_fetch_unit: RTL and testbench

- Owns the program counter and drives it out as pco_o to se_four_adder; consumes the adder's nextAddr/carry result to advance.
- Issues instruction-memory fetches with a req/gnt + rvalid handshake.
- Presents fetched instructions to decode with a valid/ready handshake.
- Handles branch/jump redirects and PC wrap-around (adder carry) faults.

---
 rtl/pc_fetch_unit_if.sv | 33 +++
 rtl/pc_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module   : pc_fetch_unit_if
// Brief    : Instruction-memory request bus and decode handshake bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pc_fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) ();
    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic               instr_valid_o;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  instr_pc_o;
    logic               instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
    );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : pc_fetch_unit
// Brief    : PC owner; fetches one instruction at a time and hands it to decode.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit #(
    parameter int                ADDR_W     = 64,
    parameter int                INSTR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    input  wire logic [ADDR_W-1:0] nextAddr_i,
    input  wire logic              carry_i,
    output logic      [ADDR_W-1:0] pco_o,
    input  wire logic              redirect_i,
    input  wire logic [ADDR_W-1:0] redirect_target_i,
    output logic                   fault_o,
    pc_fetch_unit_if.master        bus
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [ADDR_W-1:0]   w_redir_pc;
    logic                r_drop;
    logic                w_drop_nxt;
    logic                r_fault;
    logic                w_fault_nxt;
    logic                w_capture;
    logic [INSTR_W-1:0]  r_instr;
    logic [ADDR_W-1:0]   r_instr_pc;

    assign w_redir_pc = {redirect_target_i[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_fault_nxt = r_fault;
        w_capture   = 1'b0;
        if (redirect_i) begin
            // A redirect beats everything; an already-granted fetch must be drained.
            w_pc_nxt    = w_redir_pc;
            w_fault_nxt = 1'b0;
            unique case (r_state)
                S_REQ: begin
                    if (bus.imem_gnt_i) begin
                        w_state_nxt = S_WAIT;
                        w_drop_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        w_state_nxt = S_REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_BOOT: w_state_nxt = S_REQ;
                S_REQ: begin
                    if (bus.imem_gnt_i) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        if (r_drop) begin
                            w_drop_nxt  = 1'b0;
                            w_state_nxt = S_REQ;
                        end else begin
                            w_capture   = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready_i) begin
                        // PC+4 overflowing the address space is a fatal wrap.
                        if (carry_i) begin
                            w_fault_nxt = 1'b1;
                            w_state_nxt = S_HALT;
                        end else begin
                            w_pc_nxt    = nextAddr_i;
                            w_state_nxt = S_REQ;
                        end
                    end
                end
                S_HALT:  w_state_nxt = S_HALT;
                default: w_state_nxt = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc       <= RESET_ADDR;
            r_drop     <= 1'b0;
            r_fault    <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_drop  <= w_drop_nxt;
            r_fault <= w_fault_nxt;
            if (w_capture) begin
                r_instr    <= bus.imem_rdata_i;
                r_instr_pc <= r_pc;
            end
        end
    end

    assign pco_o             = r_pc;
    assign fault_o           = r_fault;
    assign bus.imem_req_o    = (r_state == S_REQ);
    assign bus.imem_addr_o   = r_pc;
    assign bus.instr_valid_o = (r_state == S_HOLD);
    assign bus.instr_o       = r_instr;
    assign bus.instr_pc_o    = r_instr_pc;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_fetch_unit
// Brief    : Scoreboard bench for pc_fetch_unit with memory and adder models.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_unit;
    localparam int C_AW = 64;
    localparam int C_IW = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [C_AW-1:0] nextAddr_i;
    logic            carry_i;
    logic [C_AW-1:0] pco_o;
    logic            redirect_i = 1'b0;
    logic [C_AW-1:0] redirect_target_i = '0;
    logic            fault_o;

    pc_fetch_unit_if #(.ADDR_W(C_AW), .INSTR_W(C_IW)) bus ();

    pc_fetch_unit #(.ADDR_W(C_AW), .INSTR_W(C_IW), .RESET_ADDR(64'h0)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .nextAddr_i        (nextAddr_i),
        .carry_i           (carry_i),
        .pco_o             (pco_o),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .fault_o           (fault_o),
        .bus               (bus)
    );

    always #5 clk_i = ~clk_i;

    // se_four_adder model
    assign {carry_i, nextAddr_i} = {1'b0, pco_o} + 65'd4;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct { logic [C_AW-1:0] pc; logic [C_IW-1:0] word; } exp_t;
    exp_t            sb[$];
    logic [C_AW-1:0] fire_log[$];
    int              hs_cyc[$];

    bit mem_auto = 1'b1;
    int rv_lat   = 0;

    function automatic logic [C_IW-1:0] mem_word(input logic [C_AW-1:0] a);
        return 32'h00500093 ^ (a[31:0] << 8);
    endfunction

    task automatic chk(input string tag, input logic [C_AW-1:0] obs, input logic [C_AW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Memory responder: one outstanding request, rvalid rv_lat cycles after grant.
    initial begin
        logic            fire, rv_now, pend;
        logic [C_AW-1:0] fa, pa;
        int              cnt;
        pend = 1'b0; cnt = 0; pa = '0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            fire   = bus.imem_req_o && bus.imem_gnt_i;
            fa     = bus.imem_addr_o;
            rv_now = bus.imem_rvalid_i;
            @(posedge clk_i);
            #1;
            if (mem_auto) begin
                if (rv_now) begin
                    pend = 1'b0;
                    bus.imem_rvalid_i = 1'b0;
                end
                if (fire) begin
                    pend = 1'b1; pa = fa; cnt = rv_lat;
                end
                if (pend && !bus.imem_rvalid_i) begin
                    if (cnt == 0) begin
                        bus.imem_rvalid_i = 1'b1;
                        bus.imem_rdata_i  = mem_word(pa);
                    end else begin
                        cnt--;
                    end
                end
                bus.imem_gnt_i = 1'b1;
            end
        end
    end

    // Monitor / scoreboard, sampling mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                sb.delete();
            end else begin
                if (bus.instr_valid_o) begin
                    chk("sb_depth", sb.size(), 1);
                    if (sb.size() > 0) begin
                        e = sb[0];
                        chk("sb_instr", bus.instr_o, e.word);
                        chk("sb_instr_pc", bus.instr_pc_o, e.pc);
                        if (bus.instr_ready_i && !redirect_i) begin
                            void'(sb.pop_front());
                            hs_cyc.push_back(cyc);
                        end
                    end
                end
                if (bus.imem_req_o && bus.imem_gnt_i) begin
                    e.pc = bus.imem_addr_o;
                    e.word = mem_word(bus.imem_addr_o);
                    sb.push_back(e);
                    fire_log.push_back(bus.imem_addr_o);
                end
                if (redirect_i) sb.delete();
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        chk("rst_pco", pco_o, 64'h0);
        chk("rst_req", bus.imem_req_o, 0);
        chk("rst_valid", bus.instr_valid_o, 0);
        chk("rst_instr", bus.instr_o, 0);
        chk("rst_instr_pc", bus.instr_pc_o, 0);
        chk("rst_fault", fault_o, 0);
        fire_log.delete();
        hs_cyc.delete();
        rst_ni = 1'b1;
    endtask

    task automatic wait_fires(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (fire_log.size() >= n) break;
        end
        if (i == budget) chk("wait_fire_timeout", fire_log.size(), n);
    endtask

    task automatic wait_valid(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            tick();
            if (bus.instr_valid_o) break;
        end
        if (i == budget) chk("wait_valid_timeout", bus.instr_valid_o, 1);
    endtask

    task automatic redirect(input logic [C_AW-1:0] tgt);
        redirect_i = 1'b1;
        redirect_target_i = tgt;
        tick();
        redirect_i = 1'b0;
    endtask

    initial begin
        int i;
        bus.instr_ready_i = 1'b1;
        #2;
        // Sequential fetch with always-ready memory and decode
        do_reset();
        wait_fires(3, 40);
        for (int k = 0; k < 12 && hs_cyc.size() < 3; k++) tick();
        if (fire_log.size() >= 3) begin
            chk("seq_addr0", fire_log[0], 64'h0);
            chk("seq_addr1", fire_log[1], 64'h4);
            chk("seq_addr2", fire_log[2], 64'h8);
        end
        if (hs_cyc.size() >= 3) begin
            chk("seq_rate01", hs_cyc[1] - hs_cyc[0], 3);
            chk("seq_rate12", hs_cyc[2] - hs_cyc[1], 3);
        end else chk("seq_hs_count", hs_cyc.size(), 3);

        // Decode stalls for five cycles
        bus.instr_ready_i = 1'b0;
        do_reset();
        wait_valid(20);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", bus.instr_valid_o, 1);
            chk("stall_instr", bus.instr_o, 32'h00500093);
            chk("stall_pco", pco_o, 64'h0);
            chk("stall_req", bus.imem_req_o, 0);
            tick();
        end
        bus.instr_ready_i = 1'b1;

        // Redirect while waiting for a slow response
        rv_lat = 2;
        fire_log.delete();
        wait_fires(1, 20);
        redirect(64'h1003);
        chk("wait_redir_pco", pco_o, 64'h1000);
        wait_fires(2, 20);
        if (fire_log.size() >= 2) chk("wait_redir_fetch", fire_log[1], 64'h1000);
        wait_valid(20);
        chk("wait_redir_instr_pc", bus.instr_pc_o, 64'h1000);
        chk("wait_redir_instr", bus.instr_o, mem_word(64'h1000));
        rv_lat = 0;

        // Redirect coinciding with acceptance in HOLD
        bus.instr_ready_i = 1'b0;
        redirect(64'h100);
        wait_valid(20);
        chk("hold_pc", bus.instr_pc_o, 64'h100);
        bus.instr_ready_i = 1'b1;
        redirect(64'h200);
        chk("hold_redir_pco", pco_o, 64'h200);
        fire_log.delete();
        wait_fires(1, 20);
        if (fire_log.size() >= 1) chk("hold_redir_fetch", fire_log[0], 64'h200);

        // PC wrap fault and recovery
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        for (i = 0; i < 20 && !fault_o; i++) tick();
        chk("wrap_fault", fault_o, 1);
        chk("wrap_pco", pco_o, 64'hFFFF_FFFF_FFFF_FFFC);
        fire_log.delete();
        for (int k = 0; k < 3; k++) begin
            chk("halt_req", bus.imem_req_o, 0);
            chk("halt_valid", bus.instr_valid_o, 0);
            tick();
        end
        chk("halt_no_fetch", fire_log.size(), 0);
        redirect(64'h80);
        chk("halt_clear_fault", fault_o, 0);
        wait_fires(1, 20);
        if (fire_log.size() >= 1) chk("halt_redir_fetch", fire_log[0], 64'h80);

        // Asynchronous reset during WAIT; stale rvalid during BOOT
        mem_auto = 1'b0;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i = mem_word(bus.imem_addr_o);
        tick();
        bus.imem_rvalid_i = 1'b0;
        repeat (3) tick();
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_pco", pco_o, 64'h0);
        chk("async_req", bus.imem_req_o, 0);
        chk("async_valid", bus.instr_valid_o, 0);
        chk("async_fault", fault_o, 0);
        tick();
        rst_ni = 1'b1;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i = 32'hDEADBEEF;
        tick();
        bus.imem_rvalid_i = 1'b0;
        chk("boot_req", bus.imem_req_o, 1);
        chk("boot_addr", bus.imem_addr_o, 64'h0);
        chk("boot_valid", bus.instr_valid_o, 0);
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i = mem_word(64'h0);
        tick();
        bus.imem_rvalid_i = 1'b0;
        chk("boot_instr_valid", bus.instr_valid_o, 1);
        chk("boot_instr", bus.instr_o, mem_word(64'h0));
        chk("boot_instr_pc", bus.instr_pc_o, 64'h0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
